// File: rtl/vga_tx.sv
// VGA timing generator with a pixel-stream input.
// Counters, syncs, data-enable and colour are registered; pix_ready is combinational.
module vga_tx #(
    parameter int HOR_ACT   = 640,
    parameter int HOR_FP    = 16,
    parameter int HOR_SYNC  = 96,
    parameter int HOR_BP    = 48,
    parameter int VERT_ACT  = 480,
    parameter int VERT_FP   = 11,
    parameter int VERT_SYNC = 2,
    parameter int VERT_BP   = 31,
    parameter int SYNC_POL  = 0
) (
    input  logic       pixel_clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] pix_r,
    input  logic [7:0] pix_g,
    input  logic [7:0] pix_b,
    input  logic       pix_valid,
    input  logic       pix_sof,
    output logic       pix_ready,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic       frame_start,
    output logic       underflow,
    output logic       sync_err
);

    localparam int H_TOTAL = HOR_ACT + HOR_FP + HOR_SYNC + HOR_BP;
    localparam int V_TOTAL = VERT_ACT + VERT_FP + VERT_SYNC + VERT_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam logic SP = (SYNC_POL != 0);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic act;
    logic origin;
    logic v_blank;
    logic consume;
    logic hs_on;
    logic vs_on;
    logic h_last;
    logic v_last;

    // Decode the current counter position into timing regions.
    always_comb begin
        h_last  = (int'(h_cnt) == H_TOTAL - 1);
        v_last  = (int'(v_cnt) == V_TOTAL - 1);
        origin  = (h_cnt == '0) && (v_cnt == '0);
        act     = en && (int'(h_cnt) < HOR_ACT)
                     && (int'(v_cnt) < VERT_ACT);
        v_blank = en && (int'(v_cnt) >= VERT_ACT);
        hs_on   = (int'(h_cnt) >= HOR_ACT + HOR_FP)
               && (int'(h_cnt) < HOR_ACT + HOR_FP + HOR_SYNC);
        vs_on   = (int'(v_cnt) >= VERT_ACT + VERT_FP)
               && (int'(v_cnt) < VERT_ACT + VERT_FP + VERT_SYNC);
    end

    // Accept the frame's first beat only at the origin; flush stray beats in vblank.
    always_comb begin
        pix_ready = 1'b0;
        if (act && origin) begin
            pix_ready = 1'b1;
        end else if (act || v_blank) begin
            pix_ready = ~pix_sof;
        end
        consume = pix_valid && pix_ready;
    end

    // Raster counters; en=0 parks them at the origin.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Registered VGA outputs and status pulses, one cycle behind the counters.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r           <= '0;
            g           <= '0;
            b           <= '0;
            de          <= 1'b0;
            hsync       <= ~SP;
            vsync       <= ~SP;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
            sync_err    <= 1'b0;
        end else if (!en) begin
            r           <= '0;
            g           <= '0;
            b           <= '0;
            de          <= 1'b0;
            hsync       <= ~SP;
            vsync       <= ~SP;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            if (act && consume) begin
                r <= pix_r;
                g <= pix_g;
                b <= pix_b;
            end else begin
                r <= '0;
                g <= '0;
                b <= '0;
            end
            de          <= act;
            hsync       <= hs_on ? SP : ~SP;
            vsync       <= vs_on ? SP : ~SP;
            frame_start <= origin;
            underflow   <= act && !pix_valid;
            sync_err    <= act && pix_valid && (pix_sof != origin);
        end
    end

endmodule

// File: tb/tb_vga_tx.sv
// Self-checking bench for vga_tx with a position-based reference model.
// Small 8x6 raster instance plus a default-parameter instance.
module tb_vga_tx;

    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic fs;
        logic uf;
        logic se;
        logic [23:0] rgb;
    } out_t;

    logic clk = 1'b0;
    logic rst_n, en, en_d, pv, ps;
    logic [7:0] pr, pg, pb;
    logic rdy, hs, vs, de, fs, uf, se;
    logic [7:0] ro, go, bo;
    logic rdy_d, hs_d, vs_d, de_d, fs_d, uf_d, se_d;
    logic [7:0] ro_d, go_d, bo_d;

    int checks = 0;
    int errors = 0;
    logic [24:0] q[$];

    always #5 clk = ~clk;

    vga_tx #(
        .HOR_ACT(HA), .HOR_FP(HF), .HOR_SYNC(HS), .HOR_BP(HB),
        .VERT_ACT(VA), .VERT_FP(VF), .VERT_SYNC(VS), .VERT_BP(VB),
        .SYNC_POL(0)
    ) dut (
        .pixel_clk(clk), .rst_n(rst_n), .en(en),
        .pix_r(pr), .pix_g(pg), .pix_b(pb),
        .pix_valid(pv), .pix_sof(ps), .pix_ready(rdy),
        .r(ro), .g(go), .b(bo),
        .hsync(hs), .vsync(vs), .de(de),
        .frame_start(fs), .underflow(uf), .sync_err(se)
    );

    vga_tx dut_d (
        .pixel_clk(clk), .rst_n(rst_n), .en(en_d),
        .pix_r(pr), .pix_g(pg), .pix_b(pb),
        .pix_valid(pv), .pix_sof(ps), .pix_ready(rdy_d),
        .r(ro_d), .g(go_d), .b(bo_d),
        .hsync(hs_d), .vsync(vs_d), .de(de_d),
        .frame_start(fs_d), .underflow(uf_d), .sync_err(se_d)
    );

    // Expected behaviour from the raster position k cycles after en rose.
    function automatic void model(input int k, input bit e, v, s,
                                  input logic [23:0] d,
                                  output logic er, output out_t o);
        int x, y;
        bit a, org;
        o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        er = 1'b0;
        if (!e) return;
        x = k % HT;
        y = (k / HT) % VT;
        org = (k % (HT * VT)) == 0;
        a = (x < HA) && (y < VA);
        if (a && org) er = 1'b1;
        else if (a || y >= VA) er = !s;
        o.de = a;
        o.hs = !(x >= HA + HF && x < HA + HF + HS);
        o.vs = !(y >= VA + VF && y < VA + VF + VS);
        o.fs = org;
        o.uf = a && !v;
        o.se = a && v && (s != org);
        o.rgb = (a && v && er) ? d : 24'h0;
    endfunction

    function automatic out_t snap();
        out_t o;
        o.de = de; o.hs = hs; o.vs = vs;
        o.fs = fs; o.uf = uf; o.se = se;
        o.rgb = {ro, go, bo};
        return o;
    endfunction

    function automatic logic [23:0] pat(input int i);
        return {8'(3 * i + 1), 8'(3 * i + 2), 8'(3 * i + 3)};
    endfunction

    function automatic void head(input bit want, output bit v, s,
                                 output logic [23:0] d);
        v = want && (q.size() > 0);
        s = v ? q[0][24] : 1'b0;
        d = v ? q[0][23:0] : 24'h0;
    endfunction

    task automatic fill(input bit rnd, input int base);
        for (int i = 0; i < HA * VA; i++)
            q.push_back({i == 0, rnd ? 24'($urandom) : pat(base + i)});
    endtask

    task automatic drive(input bit e, v, s, input logic [23:0] d);
        @(negedge clk);
        en = e; pv = v; ps = s;
        {pr, pg, pb} = d;
        #1;
    endtask

    task automatic idle();
        q.delete();
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        out_t eo;
        logic er;
        rst_n = 1'b0; en = 1'b0; en_d = 1'b0;
        pv = 1'b0; ps = 1'b0; {pr, pg, pb} = '0;
        drive(0, 1, 0, 24'h123456);
        model(0, 0, 0, 0, 0, er, eo);
        checks++;
        if (snap() !== eo) begin
            errors++;
            $display("FAIL reset_out got %h exp %h", snap(), eo);
        end
        checks++;
        if (rdy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got %b exp 0", rdy);
        end
        checks++;
        if ({hs_d, vs_d, de_d} !== 3'b110) begin
            errors++;
            $display("FAIL reset_dflt got %b exp 110", {hs_d, vs_d, de_d});
        end
        @(negedge clk); rst_n = 1'b1;
        drive(0, 1, 1, 24'h654321);
        @(posedge clk); #1;
        checks++;
        if (snap() !== eo || rdy !== 1'b0) begin
            errors++;
            $display("FAIL en_low got %h/%b exp %h/0", snap(), rdy, eo);
        end
    endtask

    task automatic test_timing();
        out_t eo, ao;
        logic er;
        bit v, s;
        logic [23:0] d;
        int hl = 0, vl = 0, dc = 0, fc = 0, ufc = 0;
        idle();
        fill(0, 0); fill(0, 12); fill(0, 24);
        for (int k = 0; k < 2 * HT * VT; k++) begin
            head(1, v, s, d);
            drive(1, v, s, d);
            model(k, 1, v, s, d, er, eo);
            checks++;
            if (rdy !== er) begin
                errors++;
                $display("FAIL tim_ready k=%0d got %b exp %b", k, rdy, er);
            end
            if (v && er) void'(q.pop_front());
            @(posedge clk); #1;
            ao = snap();
            checks++;
            if (ao !== eo) begin
                errors++;
                $display("FAIL tim_out k=%0d got %h exp %h", k, ao, eo);
            end
            hl += !ao.hs; vl += !ao.vs; dc += ao.de;
            fc += ao.fs; ufc += ao.uf;
        end
        checks++;
        if (hl != 24 || vl != 16) begin
            errors++;
            $display("FAIL tim_sync got %0d/%0d exp 24/16", hl, vl);
        end
        checks++;
        if (dc != 24 || fc != 2 || ufc != 0) begin
            errors++;
            $display("FAIL tim_de got %0d/%0d/%0d exp 24/2/0", dc, fc, ufc);
        end
    endtask

    task automatic test_data();
        logic er;
        out_t eo;
        bit v, s;
        logic [23:0] d;
        int n = 0;
        idle();
        fill(0, 0);
        for (int k = 0; k < HT * VT; k++) begin
            head(1, v, s, d);
            drive(1, v, s, d);
            model(k, 1, v, s, d, er, eo);
            if (v && rdy) void'(q.pop_front());
            @(posedge clk); #1;
            if (de) begin
                checks++;
                if ({ro, go, bo} !== pat(n)) begin
                    errors++;
                    $display("FAIL data n=%0d got %h exp %h", n, {ro, go, bo}, pat(n));
                end
                checks++;
                if (fs !== (n == 0)) begin
                    errors++;
                    $display("FAIL data_fs n=%0d got %b exp %b", n, fs, n == 0);
                end
                n++;
            end
        end
        checks++;
        if (n != 12) begin
            errors++;
            $display("FAIL data_count got %0d exp 12", n);
        end
    endtask

    task automatic test_underflow();
        out_t eo, ao;
        logic er;
        bit v, s;
        logic [23:0] d;
        int ufc = 0;
        idle();
        fill(0, 0);
        for (int k = 0; k < HT * VT; k++) begin
            head(k != 10, v, s, d);
            drive(1, v, s, d);
            model(k, 1, v, s, d, er, eo);
            if (v && rdy) void'(q.pop_front());
            @(posedge clk); #1;
            ao = snap();
            checks++;
            if (ao !== eo) begin
                errors++;
                $display("FAIL uf_out k=%0d got %h exp %h", k, ao, eo);
            end
            ufc += ao.uf;
            if (k == 10) begin
                checks++;
                if (!ao.uf || !ao.de || ao.rgb !== 24'h0) begin
                    errors++;
                    $display("FAIL uf_pix got %h exp uf,de,rgb=0", ao);
                end
            end
            if (k == 11) begin
                checks++;
                if (ao.rgb !== pat(6)) begin
                    errors++;
                    $display("FAIL uf_next got %h exp %h", ao.rgb, pat(6));
                end
            end
        end
        checks++;
        if (ufc != 1 || q.size() != 0) begin
            errors++;
            $display("FAIL uf_count got %0d/%0d exp 1/0", ufc, q.size());
        end
    endtask

    task automatic test_misalign();
        out_t eo, ao;
        logic er;
        bit v, s;
        logic [23:0] d;
        int sec = 0, rc = 0;
        idle();
        fill(0, 0);
        for (int k = 0; k < HT * VT + 2; k++) begin
            head(k != 0, v, s, d);
            drive(1, v, s, d);
            model(k, 1, v, s, d, er, eo);
            if (k >= 1 && k < HT * VT) rc += rdy;
            if (v && rdy) void'(q.pop_front());
            @(posedge clk); #1;
            ao = snap();
            checks++;
            if (ao !== eo) begin
                errors++;
                $display("FAIL mis_out k=%0d got %h exp %h", k, ao, eo);
            end
            if (k < HT * VT) sec += ao.se;
            if (k == HT * VT) begin
                checks++;
                if (ao.rgb !== pat(0) || !ao.fs) begin
                    errors++;
                    $display("FAIL mis_resync got %h exp %h", ao.rgb, pat(0));
                end
            end
        end
        checks++;
        if (rc != 0 || sec != 11) begin
            errors++;
            $display("FAIL mis_count got %0d/%0d exp 0/11", rc, sec);
        end
    endtask

    task automatic test_random();
        out_t eo, ao;
        logic er;
        bit v, s, e;
        logic [23:0] d;
        int k = 0;
        idle();
        for (int i = 0; i < 600; i++) begin
            if (q.size() < 4) fill(1, 0);
            e = $urandom_range(0, 199) != 0;
            head($urandom_range(0, 9) < 8, v, s, d);
            drive(e, v, s, d);
            model(k, e, v, s, d, er, eo);
            checks++;
            if (rdy !== er) begin
                errors++;
                $display("FAIL rnd_ready i=%0d got %b exp %b", i, rdy, er);
            end
            if (v && er) void'(q.pop_front());
            @(posedge clk); #1;
            ao = snap();
            checks++;
            if (ao !== eo) begin
                errors++;
                $display("FAIL rnd_out i=%0d got %h exp %h", i, ao, eo);
            end
            k = e ? k + 1 : 0;
        end
    endtask

    task automatic test_reset_mid();
        out_t eo, ao;
        logic er;
        bit v, s;
        logic [23:0] d;
        idle();
        fill(0, 0);
        for (int k = 0; k < 2 * HT + 2; k++) begin
            head(1, v, s, d);
            drive(1, v, s, d);
            if (v && rdy) void'(q.pop_front());
            @(posedge clk); #1;
        end
        head(1, v, s, d);
        drive(1, v, s, d);
        rst_n = 1'b0;
        #1;
        model(0, 0, 0, 0, 0, er, eo);
        checks++;
        if (snap() !== eo) begin
            errors++;
            $display("FAIL rst_mid got %h exp %h", snap(), eo);
        end
        drive(0, 1, 0, 24'h111111);
        checks++;
        if (rdy !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready got %b exp 0", rdy);
        end
        @(negedge clk); rst_n = 1'b1;
        q.delete();
        fill(0, 0);
        head(1, v, s, d);
        drive(1, v, s, d);
        model(0, 1, v, s, d, er, eo);
        @(posedge clk); #1;
        ao = snap();
        checks++;
        if (ao !== eo || !ao.fs) begin
            errors++;
            $display("FAIL rst_restart got %h exp %h", ao, eo);
        end
    endtask

    task automatic test_defaults();
        int hl = 0, vl = 0, dc = 0, fc = 0, first = -1;
        idle();
        @(negedge clk); en_d = 1'b1;
        for (int i = 1; i <= 1600; i++) begin
            @(posedge clk); #1;
            if (!hs_d && first < 0) first = i;
            hl += !hs_d; vl += !vs_d; dc += de_d; fc += fs_d;
        end
        en_d = 1'b0;
        checks++;
        if (hl != 192 || first != 657) begin
            errors++;
            $display("FAIL dflt_hs got %0d@%0d exp 192@657", hl, first);
        end
        checks++;
        if (vl != 0 || dc != 1280 || fc != 1) begin
            errors++;
            $display("FAIL dflt_de got %0d/%0d/%0d exp 0/1280/1", vl, dc, fc);
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_data();
        test_underflow();
        test_misalign();
        test_random();
        test_reset_mid();
        test_defaults();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
